// File: rtl/out_display_driver.sv
// out_display_driver
// Converts the SAP-1 OUT byte into three BCD digits with a sequential
// shift-add-3 engine, then scans them onto a 3-digit common-anode
// 7-segment display with leading-zero blanking.
//
// Handshake: none. data_in is level-sampled while idle; a new conversion
// starts whenever data_in differs from the last accepted value. busy is
// high for exactly 8 cycles per conversion and bcd is valid whenever busy
// is low. Changes of data_in while busy are picked up on the first idle
// cycle afterwards.
module out_display_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_in,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic [11:0] bcd,
   output logic        busy,
   output logic        dbg_state
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [2:0] AN_BLANK  = 3'b111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     last_q, last_d;
   logic [19:0]    shreg_q, shreg_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [11:0]    bcd_q, bcd_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [1:0]     dig_q, dig_d;
   logic [6:0]     seg_q, seg_d;
   logic [2:0]     an_q, an_d;

   logic [19:0]    adj;
   logic [19:0]    shifted;
   logic [3:0]     hund, tens, ones;

   // Double-dabble correction: a nibble of 5 or more would overflow past 9
   // when doubled, so it is pre-biased by 3.
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Active-low gfedcba patterns; anything outside 0..9 goes dark.
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // One shift-add-3 step of the conversion register.
   always_comb begin
      adj     = {add3(shreg_q[19:16]), add3(shreg_q[15:12]),
                 add3(shreg_q[11:8]), shreg_q[7:0]};
      shifted = adj << 1;
   end

   // Conversion FSM: next state and datapath updates.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         S_IDLE: begin
            if (data_in != last_q) begin
               last_d  = data_in;
               shreg_d = {12'h000, data_in};
               cnt_d   = 3'd0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            shreg_d = shifted;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               bcd_d   = shifted[19:8];
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign hund = bcd_q[11:8];
   assign tens = bcd_q[7:4];
   assign ones = bcd_q[3:0];

   // Scan prescaler, digit rotation and registered segment/anode drive.
   always_comb begin
      presc_d = presc_q + 1'b1;
      dig_d   = dig_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         case (dig_q)
            2'd0:    dig_d = 2'd1;
            2'd1:    dig_d = 2'd2;
            default: dig_d = 2'd0;
         endcase
      end

      seg_d = SEG_BLANK;
      an_d  = AN_BLANK;
      case (dig_q)
         2'd0: begin
            an_d  = 3'b110;
            seg_d = seg_of(ones);
         end
         2'd1: begin
            if (!(hund == 4'd0 && tens == 4'd0)) begin
               an_d  = 3'b101;
               seg_d = seg_of(tens);
            end
         end
         2'd2: begin
            if (hund != 4'd0) begin
               an_d  = 3'b011;
               seg_d = seg_of(hund);
            end
         end
         default: begin
            an_d  = AN_BLANK;
            seg_d = SEG_BLANK;
         end
      endcase
   end

   // State and datapath registers; reset also aborts any conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= 8'h00;
         shreg_q <= 20'h00000;
         cnt_q   <= 3'd0;
         bcd_q   <= 12'h000;
         presc_q <= '0;
         dig_q   <= 2'd0;
         seg_q   <= 7'b1000000;
         an_q    <= 3'b110;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         presc_q <= presc_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign bcd       = bcd_q;
   assign busy      = (state_q == S_CONV);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_out_display_driver.sv
// Testbench for out_display_driver with a short scan period.
module tb_out_display_driver;

   localparam int SCAN_DIV = 4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic [11:0] bcd;
   logic        busy;
   logic        dbg_state;

   always #5 clk = ~clk;

   out_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .seg       (seg),
      .an        (an),
      .bcd       (bcd),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- reference model ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [11:0] exp_q[$];
   int last_m = 0;

   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000};

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Expected {an, seg} for slot 0=ones, 1=tens, 2=hundreds.
   function automatic logic [9:0] exp_slot(input int v, input int slot);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      if (slot == 0) return {3'b110, seg_tab[o]};
      if (slot == 1) return (h == 0 && t == 0) ? 10'h3FF : {3'b101, seg_tab[t]};
      return (h == 0) ? 10'h3FF : {3'b011, seg_tab[h]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int busy_len  = 0;
   bit busy_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_prev = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy) begin
            busy_len++;
         end else if (busy_prev) begin
            check("busy_len", busy_len, 8);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_conv: got bcd %0h with nothing expected", bcd);
            end else begin
               check("sb_bcd", bcd, exp_q.pop_front());
            end
            busy_len = 0;
         end
         busy_prev = busy;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle_timeout: busy still %0b expected 0", busy);
      end
   endtask

   task automatic convert(input int v);
      @(posedge clk);
      #1 data_in = 8'(v);
      if (v != last_m) begin
         exp_q.push_back(to_bcd(v));
         last_m = v;
      end
      @(posedge clk);
      #1;
      wait_idle();
      check($sformatf("final_bcd_%0d", v), bcd, to_bcd(v));
   endtask

   task automatic scan_check(input int v);
      logic [2:0] prev_an;
      bit found = 1'b0;
      @(negedge clk);
      prev_an = an;
      for (int i = 0; i < 4 * SCAN_DIV && !found; i++) begin
         @(negedge clk);
         if (an == 3'b110 && prev_an != 3'b110) found = 1'b1;
         else prev_an = an;
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL scan_sync_%0d: an %b never entered ones slot", v, an);
      end else begin
         for (int c = 0; c < 3 * SCAN_DIV; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("scan_v%0d_c%0d", v, c), {an, seg}, exp_slot(v, c / SCAN_DIV));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   int order[256];

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_seg", seg, 7'b1000000);
      check("rst_an", an, 3'b110);
      check("rst_bcd", bcd, 12'h000);
      check("rst_busy", busy, 1'b0);
      repeat (10) @(negedge clk);
      check("idle_busy", busy, 1'b0);

      // full scale and blanking
      convert(255);
      scan_check(255);
      convert(7);
      scan_check(7);
      convert(40);
      scan_check(40);

      // change during conversion
      @(posedge clk);
      #1 data_in = 8'd100;
      exp_q.push_back(12'h100);
      repeat (3) @(posedge clk);
      #1 data_in = 8'd42;
      exp_q.push_back(12'h042);
      last_m = 42;
      wait_idle();
      check("mid_first_bcd", bcd, 12'h100);
      @(negedge clk);
      check("mid_gap_busy", busy, 1'b1);
      wait_idle();
      check("mid_second_bcd", bcd, 12'h042);
      scan_check(42);

      // reset during conversion
      @(posedge clk);
      #1 data_in = 8'd200;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_bcd", bcd, 12'h000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back(12'h200);
      last_m = 200;
      @(posedge clk);
      #1;
      wait_idle();
      check("after_abort_bcd", bcd, 12'h200);
      scan_check(200);

      // every value, shuffled
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(0, i));
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 256; i++) convert(order[i]);

      // a few random values through the display
      for (int i = 0; i < 4; i++) begin
         int v;
         v = int'($urandom_range(0, 255));
         convert(v);
         scan_check(v);
      end

      repeat (3) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
